// File: rtl/exec_pc_unit_pkg.sv
// Shared definitions for the execute/next-PC block: ALU operation codes and
// the sequential PC increment.
package exec_pc_unit_pkg;

  localparam int ALU_OP_W     = 4;
  localparam int PC_INCREMENT = 4;

  // Codes 14 and 15 are unused and produce a zero result.
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_EQ   = 4'd10,
    ALU_NE   = 4'd11,
    ALU_GE   = 4'd12,
    ALU_GEU  = 4'd13
  } alu_op_e;

endpackage

// File: rtl/exec_alu.sv
// Integer ALU: purely combinational, operands and op code in, result out.
// Compare operations return a zero-extended 0/1; add/sub wrap silently.
module exec_alu
  import exec_pc_unit_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic [ALU_OP_W-1:0]  alu_op,
  input  logic [DataWidth-1:0] a,
  input  logic [DataWidth-1:0] b,
  output logic [DataWidth-1:0] result
);

  alu_op_e    op;
  logic [4:0] shamt;

  assign op    = alu_op_e'(alu_op);
  assign shamt = b[4:0];

  // Select the result of the requested operation.
  always_comb begin
    // NOTE: result gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    result = '0;
    unique case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = DataWidth'($signed(a) < $signed(b));
      ALU_SLTU: result = DataWidth'(a < b);
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = DataWidth'($signed(a) >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_EQ:   result = DataWidth'(a == b);
      ALU_NE:   result = DataWidth'(a != b);
      ALU_GE:   result = DataWidth'($signed(a) >= $signed(b));
      ALU_GEU:  result = DataWidth'(a >= b);
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/exec_pc_unit.sv
// Execute and next-PC block of the single-cycle core. Holds the PC, forms
// PC+4, runs the ALU and resolves jal/jalr/branch into the next PC. The PC
// register is the only state; everything else is combinational.
// Optional feature: define EXEC_MISALIGN_CHECK_EN to flag taken transfers to
// non-word-aligned targets and hold the PC instead of loading them.
module exec_pc_unit
  import exec_pc_unit_pkg::*;
#(
  parameter int                   DataWidth = 32,
  parameter logic [DataWidth-1:0] ResetPc   = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ALU_OP_W-1:0]  alu_op_i,
  input  logic                 alu_src_i,
  input  logic [DataWidth-1:0] rs1_data_i,
  input  logic [DataWidth-1:0] rs2_data_i,
  input  logic [DataWidth-1:0] imm_i,
  input  logic                 jal_i,
  input  logic                 jalr_i,
  input  logic                 branch_i,
  output logic [DataWidth-1:0] pc_o,
  output logic [DataWidth-1:0] pc_plus4_o,
  output logic [DataWidth-1:0] alu_result_o,
  output logic                 alu_flag_o,
  output logic [DataWidth-1:0] pc_target_o,
  output logic                 pc_src_sel_o,
  output logic                 misaligned_o
);

  // JALR clears bit 0 of the computed address.
  localparam logic [DataWidth-1:0] JalrMask = ~DataWidth'(1);

  logic [DataWidth-1:0] pc_q;
  logic [DataWidth-1:0] pc_next;
  logic [DataWidth-1:0] operand_b;
  logic [DataWidth-1:0] jalr_target;
  logic [DataWidth-1:0] pc_rel_target;

  assign operand_b = alu_src_i ? imm_i : rs2_data_i;

  exec_alu #(
    .DataWidth (DataWidth)
  ) u_alu (
    .alu_op (alu_op_i),
    .a      (rs1_data_i),
    .b      (operand_b),
    .result (alu_result_o)
  );

  assign alu_flag_o = alu_result_o[0];

  // Target is always driven: the PC-relative sum doubles as the AUIPC value.
  assign jalr_target   = (rs1_data_i + imm_i) & JalrMask;
  assign pc_rel_target = pc_q + imm_i;
  assign pc_target_o   = jalr_i ? jalr_target : pc_rel_target;

  assign pc_src_sel_o = jal_i | jalr_i | (branch_i & alu_flag_o);

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_q + DataWidth'(PC_INCREMENT);

`ifdef EXEC_MISALIGN_CHECK_EN
  assign misaligned_o = pc_src_sel_o & (pc_target_o[1] | pc_target_o[0]);
`else
  assign misaligned_o = 1'b0;
`endif

  // Choose the next PC: hold on a flagged misaligned transfer, else target or PC+4.
  always_comb begin
    pc_next = pc_plus4_o;
    if (misaligned_o) begin
      pc_next = pc_q;
    end else if (pc_src_sel_o) begin
      pc_next = pc_target_o;
    end
  end

  // PC register; reset wins over any taken transfer in the same cycle.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    if (rst_i) begin
      pc_q <= ResetPc;
    end else begin
      pc_q <= pc_next;
    end
  end

endmodule

// File: tb/tb_exec_pc_unit.sv
// Directed bench for exec_pc_unit: reset, sequential fetch, ALU ops, branch,
// jal/jalr, AUIPC target, reset override and the misaligned-target behaviour
// (expectation follows EXEC_MISALIGN_CHECK_EN).
module tb_exec_pc_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  alu_op_i;
  logic        alu_src_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [31:0] imm_i;
  logic        jal_i;
  logic        jalr_i;
  logic        branch_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [31:0] alu_result_o;
  logic        alu_flag_o;
  logic [31:0] pc_target_o;
  logic        pc_src_sel_o;
  logic        misaligned_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  exec_pc_unit #(
    .DataWidth (32),
    .ResetPc   (32'h0)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .alu_op_i     (alu_op_i),
    .alu_src_i    (alu_src_i),
    .rs1_data_i   (rs1_data_i),
    .rs2_data_i   (rs2_data_i),
    .imm_i        (imm_i),
    .jal_i        (jal_i),
    .jalr_i       (jalr_i),
    .branch_i     (branch_i),
    .pc_o         (pc_o),
    .pc_plus4_o   (pc_plus4_o),
    .alu_result_o (alu_result_o),
    .alu_flag_o   (alu_flag_o),
    .pc_target_o  (pc_target_o),
    .pc_src_sel_o (pc_src_sel_o),
    .misaligned_o (misaligned_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total_cnt++;
    assert (observed === expected) pass_cnt++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
  endtask

  // Advance one rising edge, then settle away from the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    alu_op_i   = 4'd0;
    alu_src_i  = 1'b0;
    rs1_data_i = '0;
    rs2_data_i = '0;
    imm_i      = '0;
    jal_i      = 1'b0;
    jalr_i     = 1'b0;
    branch_i   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  // Load an arbitrary PC through jalr (target bit 0 is cleared).
  task automatic set_pc(input logic [31:0] value);
    idle_inputs();
    jalr_i     = 1'b1;
    rs1_data_i = value;
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    tick();
    check("reset_pc", pc_o, 32'h0);
    check("reset_pc_plus4", pc_plus4_o, 32'h4);

    // Sequential fetch.
    rst_i = 1'b0;
    tick();
    check("seq_pc_4", pc_o, 32'h4);
    tick();
    check("seq_pc_8", pc_o, 32'h8);
    tick();
    check("seq_pc_12", pc_o, 32'hC);
    check("seq_plus4_16", pc_plus4_o, 32'h10);

    // ALU with register operand.
    rs1_data_i = 32'hFFFF_FFF0;
    rs2_data_i = 32'h0000_0010;
    alu_op_i = 4'd0;  #1; check("alu_add", alu_result_o, 32'h0);
    alu_op_i = 4'd1;  #1; check("alu_sub", alu_result_o, 32'hFFFF_FFE0);
    alu_op_i = 4'd3;  #1; check("alu_slt", alu_result_o, 32'h1);
                          check("alu_slt_flag", {31'b0, alu_flag_o}, 32'h1);
    alu_op_i = 4'd4;  #1; check("alu_sltu", alu_result_o, 32'h0);
    alu_op_i = 4'd15; #1; check("alu_op15", alu_result_o, 32'h0);
    alu_op_i = 4'd14; #1; check("alu_op14", alu_result_o, 32'h0);
    alu_op_i = 4'd5;  #1; check("alu_xor", alu_result_o, 32'hFFFF_FFE0);
    alu_op_i = 4'd12; #1; check("alu_ge", alu_result_o, 32'h0);
    alu_op_i = 4'd13; #1; check("alu_geu", alu_result_o, 32'h1);

    // ALU with immediate operand (shift by 4).
    alu_src_i = 1'b1;
    imm_i     = 32'h0000_0004;
    alu_op_i = 4'd7;  #1; check("alu_sra4", alu_result_o, 32'hFFFF_FFFF);
    alu_op_i = 4'd6;  #1; check("alu_srl4", alu_result_o, 32'h0FFF_FFFF);
    alu_op_i = 4'd2;  #1; check("alu_sll4", alu_result_o, 32'hFFFF_FF00);
    idle_inputs();

    // Taken branch from 0x20 back to 0x18.
    do_reset();
    set_pc(32'h20);
    check("br_start_pc", pc_o, 32'h20);
    branch_i   = 1'b1;
    alu_op_i   = 4'd10;
    rs1_data_i = 32'd5;
    rs2_data_i = 32'd5;
    imm_i      = 32'hFFFF_FFF8;
    #1;
    check("br_taken_target", pc_target_o, 32'h18);
    check("br_taken_sel", {31'b0, pc_src_sel_o}, 32'h1);
    tick();
    check("br_taken_pc", pc_o, 32'h18);

    // Not-taken branch from 0x20.
    set_pc(32'h20);
    branch_i   = 1'b1;
    alu_op_i   = 4'd10;
    rs1_data_i = 32'd5;
    rs2_data_i = 32'd6;
    imm_i      = 32'hFFFF_FFF8;
    #1;
    check("br_nt_sel", {31'b0, pc_src_sel_o}, 32'h0);
    tick();
    check("br_nt_pc", pc_o, 32'h24);

    // Flag set but no branch strobe: no transfer.
    idle_inputs();
    alu_op_i   = 4'd10;
    rs1_data_i = 32'd7;
    rs2_data_i = 32'd7;
    #1;
    check("flag_no_branch_sel", {31'b0, pc_src_sel_o}, 32'h0);

    // JALR with odd base: bit 0 cleared.
    idle_inputs();
    jalr_i     = 1'b1;
    rs1_data_i = 32'h101;
    imm_i      = 32'h4;
    #1;
    check("jalr_target", pc_target_o, 32'h104);
    check("jalr_sel", {31'b0, pc_src_sel_o}, 32'h1);
    tick();
    check("jalr_pc", pc_o, 32'h104);

    // JAL from 0x100.
    set_pc(32'h100);
    jal_i = 1'b1;
    imm_i = 32'h40;
    #1;
    check("jal_target", pc_target_o, 32'h140);
    tick();
    check("jal_pc", pc_o, 32'h140);

    // jal and jalr together: jalr target wins.
    jal_i      = 1'b1;
    jalr_i     = 1'b1;
    rs1_data_i = 32'h200;
    imm_i      = 32'h8;
    #1;
    check("prio_target", pc_target_o, 32'h208);
    tick();
    check("prio_pc", pc_o, 32'h208);

    // AUIPC path: target driven without a transfer.
    set_pc(32'h1000);
    imm_i = 32'h0000_3000;
    #1;
    check("auipc_target", pc_target_o, 32'h4000);
    check("auipc_sel", {31'b0, pc_src_sel_o}, 32'h0);
    tick();
    check("auipc_pc", pc_o, 32'h1004);

    // PC wraps past the top of the address space.
    set_pc(32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4_o, 32'h0);
    tick();
    check("wrap_pc", pc_o, 32'h0);

    // Reset overrides a taken jump.
    set_pc(32'h80);
    jal_i = 1'b1;
    imm_i = 32'h40;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rst_override_pc", pc_o, 32'h0);

    // Misaligned jal target.
    do_reset();
    jal_i = 1'b1;
    imm_i = 32'h6;
    #1;
    check("mis_target", pc_target_o, 32'h6);
`ifdef EXEC_MISALIGN_CHECK_EN
    check("mis_flag", {31'b0, misaligned_o}, 32'h1);
    tick();
    check("mis_pc_held", pc_o, 32'h0);
`else
    check("mis_flag", {31'b0, misaligned_o}, 32'h0);
    tick();
    check("mis_pc_loaded", pc_o, 32'h6);
`endif
    idle_inputs();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
